ep2_port_demux: RTL and testbench
=================================

Name: ep2_port_demux

Overview:
Sits between the EP2 (host-to-device) byte stream and the four write-port FIFOs that the memory arbitrator drains into cellram. It parses a framed byte stream with a port number and length header. Payload bytes are steered into the selected port FIFO. The block also keeps per-port cumulative byte counts, which the arbitrator latches as its write-side byte counts.

Parameters:
NUM_PORTS, 4, number of write-port FIFOs (1..8)
PORT_BITS, 3, width of the port field used from header byte 0
COUNT_WIDTH, 32, width of each per-port byte counter

Ports:
clk  input  1  system clock
reset  input  1  reset reset, synchronous, active-high; clock clk
in_data  input  8  EP2 stream byte
in_valid  input  1  in_data is valid
in_ready  output  1  block accepts in_data this cycle
fifo_data  output  8  byte to the port FIFOs (shared bus)
fifo_write  output  NUM_PORTS  one-hot write strobe, bit i for port i
fifo_full  input  NUM_PORTS  full flag of each port FIFO
byte_counts  output  COUNT_WIDTH*NUM_PORTS  cumulative bytes written per port; port i occupies bits [(i+1)*COUNT_WIDTH-1 : i*COUNT_WIDTH]
busy  output  1  high when not in HDR_PORT state
bad_port  output  1  one-cycle pulse when a header names a port >= NUM_PORTS

Behaviour:
- Transfer rule: a byte is consumed when in_valid && in_ready on a rising clk edge.
- Frame format:
  - byte0: port; only bits [PORT_BITS-1:0] are used, upper bits are ignored.
  - byte1: length[15:8].
  - byte2: length[7:0].
  - followed by exactly length payload bytes.
- FSM states: HDR_PORT, HDR_LEN_HI, HDR_LEN_LO, PAYLOAD, DISCARD.
- HDR_PORT: in_ready=1. On accept, latch port and go to HDR_LEN_HI.
- HDR_LEN_HI: in_ready=1. On accept, latch length[15:8] and go to HDR_LEN_LO.
- HDR_LEN_LO: in_ready=1. On accept, form the 16-bit remaining count, then:
  - length==0: go to HDR_PORT.
  - latched port >= NUM_PORTS: go to DISCARD and pulse bad_port (registered, high the cycle after the accept).
  - otherwise: go to PAYLOAD.
- PAYLOAD:
  - in_ready = !fifo_full[port] (combinational).
  - fifo_write[port] = in_valid && in_ready; fifo_data = in_data. This path is combinational, so there is zero latency from stream to FIFO.
  - Each write decrements remaining. The write that takes remaining from 1 to 0 returns the FSM to HDR_PORT on the same edge.
- DISCARD: in_ready=1. Consumes and drops bytes, decrementing remaining. Returns to HDR_PORT after the last byte. fifo_write stays 0.
- fifo_write is zero in every state except PAYLOAD.
- fifo_data equals in_data in all states; it is don't-care when no strobe is asserted.
- byte_counts:
  - Registered; increment by 1 on the edge where the matching fifo_write bit is high.
  - Visible the cycle after the write.
  - Wrap modulo 2^COUNT_WIDTH with no saturation.
  - The arbitrator uses differences of these counts, so wrap is legal.
- fifo_full rising mid-payload: stall with in_ready=0. Hold state and remaining; nothing is lost.
- in_valid low mid-frame: hold state indefinitely. There is no timeout.
- Reset:
  - FSM goes to HDR_PORT; port, remaining and all byte_counts go to 0.
  - in_ready=1 on the first cycle after reset is released; busy=0, bad_port=0, fifo_write=0.
  - Reset mid-frame abandons the frame. Remaining payload bytes are then parsed as headers; host resync is the host's responsibility.

Optional Feature:
Macro EP2_DEMUX_DROP_COUNT_EN.
- Defined:
  - Adds output drop_count [15:0]. It increments once per byte consumed in DISCARD, saturating at 16'hFFFF, and resets to 0.
  - Adds output frame_count [15:0]. It increments on every completed frame (length 0, PAYLOAD finish or DISCARD finish), wraps, and resets to 0.
- Not defined: neither port exists and there is no extra logic. All other behaviour is identical.

Test Plan:
1. Frame port=2, len=4, payload 11 22 33 44, fifo_full=0, in_valid held high -> fifo_write=4'b0100 on 4 consecutive accepts with fifo_data 11,22,33,44 in order; byte_counts port2 reads 4, others 0; busy drops the cycle after the last byte.
2. Frame port=1, len=3 (AA BB CC), fifo_full[1] driven high for 5 cycles after the first payload byte -> in_ready=0 for exactly those 5 cycles; all 3 bytes written exactly once; port1 count=3.
3. Frame port=5 (NUM_PORTS=4), len=2, followed by frame port=0, len=1 (7E) -> bad_port pulses once; no fifo_write during the first frame; port0 receives 7E; port0 count=1. With the macro: drop_count=2, frame_count=2.
4. Frames port=3 len=0, then port=3 len=1 (55) -> no write for the first frame; FSM returns to HDR_PORT after 3 header bytes; one write of 55; port3 count=1.
5. Force port0 count to 32'hFFFFFFFF by preload (or run a long frame), then send 1 byte to port0 -> count wraps to 0.
6. Assert reset during PAYLOAD of a port=1 len=10 frame after 4 bytes -> all counts 0, fifo_write=0, in_ready=1, busy=0; a following clean frame port=0 len=2 lands in port0 only.

Source files
------------

// File: rtl/ep2_port_demux.sv
// ep2_port_demux: parses the EP2 host-to-device byte stream into framed
// writes for the per-port write FIFOs.
// Frame layout is one port byte, then length high and length low bytes, then
// 'length' payload bytes.
// Payload is steered combinationally onto the shared FIFO bus.
// Per-port cumulative byte counts feed the memory arbitrator.
// Optional feature macro: EP2_DEMUX_DROP_COUNT_EN adds drop_count and
// frame_count statistics outputs.
module ep2_port_demux #(
  parameter int NUM_PORTS   = 4,
  parameter int PORT_BITS   = 3,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [7:0]                         in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [7:0]                         fifo_data,
  output logic [NUM_PORTS-1:0]               fifo_write,
  input  logic [NUM_PORTS-1:0]               fifo_full,
  output logic [COUNT_WIDTH*NUM_PORTS-1:0]   byte_counts,
  output logic                               busy,
  output logic                               bad_port
`ifdef EP2_DEMUX_DROP_COUNT_EN
  ,
  output logic [15:0]                        drop_count,
  output logic [15:0]                        frame_count
`endif
);

  typedef enum logic [2:0] {
    HDR_PORT,
    HDR_LEN_HI,
    HDR_LEN_LO,
    PAYLOAD,
    DISCARD
  } state_t;

  state_t                 state_p1;
  state_t                 state_nxt;
  logic [PORT_BITS-1:0]   port_p1;
  logic [7:0]             len_hi_p1;
  logic [15:0]            remaining_p1;
  logic                   bad_port_p1;
  logic [COUNT_WIDTH-1:0] cnt_p1 [NUM_PORTS];

  logic [NUM_PORTS-1:0]   port_sel;
  logic                   port_full;
  logic                   port_ok;
  logic                   accept;
  logic                   last_byte;
  logic [15:0]            hdr_len;
  logic                   frame_done;

  // Decode the latched port into a one-hot select and look up its full flag.
  always_comb begin
    port_sel  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_sel[i] = (port_p1 == PORT_BITS'(i));
    end
    port_full = |(port_sel & fifo_full);
    port_ok   = (32'(port_p1) < NUM_PORTS);
  end

  // Handshake, zero-latency FIFO steering and status outputs.
  always_comb begin
    in_ready   = (state_p1 == PAYLOAD) ? !port_full : 1'b1;
    accept     = in_valid && in_ready;
    fifo_data  = in_data;
    fifo_write = (state_p1 == PAYLOAD && accept) ? port_sel : '0;
    busy       = (state_p1 != HDR_PORT);
    bad_port   = bad_port_p1;
    last_byte  = (remaining_p1 == 16'd1);
    hdr_len    = {len_hi_p1, in_data};
    frame_done = accept &&
                 (((state_p1 == HDR_LEN_LO) && (hdr_len == 16'd0)) ||
                  (((state_p1 == PAYLOAD) || (state_p1 == DISCARD)) && last_byte));
  end

  // Next-state logic for the frame parser.
  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      HDR_PORT:   if (accept) state_nxt = HDR_LEN_HI;
      HDR_LEN_HI: if (accept) state_nxt = HDR_LEN_LO;
      HDR_LEN_LO: begin
        if (accept) begin
          if (hdr_len == 16'd0) state_nxt = HDR_PORT;
          else if (!port_ok)    state_nxt = DISCARD;
          else                  state_nxt = PAYLOAD;
        end
      end
      PAYLOAD:    if (accept && last_byte) state_nxt = HDR_PORT;
      DISCARD:    if (accept && last_byte) state_nxt = HDR_PORT;
      default:    state_nxt = HDR_PORT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_p1 <= HDR_PORT;
    else       state_p1 <= state_nxt;
  end

  // Header capture, remaining-byte countdown and the bad-port pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      port_p1      <= '0;
      len_hi_p1    <= '0;
      remaining_p1 <= '0;
      bad_port_p1  <= 1'b0;
    end else begin
      bad_port_p1 <= 1'b0;
      if (accept) begin
        case (state_p1)
          HDR_PORT:   port_p1   <= in_data[PORT_BITS-1:0];
          HDR_LEN_HI: len_hi_p1 <= in_data;
          HDR_LEN_LO: begin
            remaining_p1 <= hdr_len;
            bad_port_p1  <= (hdr_len != 16'd0) && !port_ok;
          end
          PAYLOAD, DISCARD: remaining_p1 <= remaining_p1 - 16'd1;
          default: ;
        endcase
      end
    end
  end

  // Per-port cumulative write counters; wrap is intentional because the
  // arbitrator only ever consumes differences.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (reset)              cnt_p1[i] <= '0;
      else if (fifo_write[i]) cnt_p1[i] <= cnt_p1[i] + COUNT_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
    assign byte_counts[(g+1)*COUNT_WIDTH-1 : g*COUNT_WIDTH] = cnt_p1[g];
  end

`ifdef EP2_DEMUX_DROP_COUNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] drop_cnt_p1;
  logic [15:0] frame_cnt_p1;

  // Discarded-byte counter saturates; frame counter wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_p1  <= '0;
      frame_cnt_p1 <= '0;
    end else begin
      if (accept && state_p1 == DISCARD) drop_cnt_p1 <= sat_inc16(drop_cnt_p1);
      if (frame_done)                    frame_cnt_p1 <= frame_cnt_p1 + 16'd1;
    end
  end

  assign drop_count  = drop_cnt_p1;
  assign frame_count = frame_cnt_p1;
`else
  logic unused_frame_done;
  assign unused_frame_done = frame_done;
`endif

endmodule

// File: tb/tb_ep2_port_demux.sv
// Directed bench for ep2_port_demux. A second instance with 3-bit counters
// shares the stimulus so counter wrap can be reached in a few bytes.
module tb_ep2_port_demux;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [3:0]  fifo_full;
  logic        in_ready, busy, bad_port;
  logic [7:0]  fifo_data;
  logic [3:0]  fifo_write;
  logic [127:0] byte_counts;
  logic        in_ready_s, busy_s, bad_port_s;
  logic [7:0]  fifo_data_s;
  logic [3:0]  fifo_write_s;
  logic [11:0] byte_counts_s;
`ifdef EP2_DEMUX_DROP_COUNT_EN
  logic [15:0] drop_count, frame_count, drop_count_s, frame_count_s;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int bp_cnt   = 0;
  int exp_cnt [4];
  logic [3:0] wr_strb [$];
  logic [7:0] wr_data [$];

  always #5 clk = ~clk;

  ep2_port_demux #(.NUM_PORTS(4), .PORT_BITS(3), .COUNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .fifo_data(fifo_data), .fifo_write(fifo_write),
    .fifo_full(fifo_full), .byte_counts(byte_counts), .busy(busy),
    .bad_port(bad_port)
`ifdef EP2_DEMUX_DROP_COUNT_EN
    , .drop_count(drop_count), .frame_count(frame_count)
`endif
  );

  ep2_port_demux #(.NUM_PORTS(4), .PORT_BITS(3), .COUNT_WIDTH(3)) dut_s (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_s), .fifo_data(fifo_data_s), .fifo_write(fifo_write_s),
    .fifo_full(fifo_full), .byte_counts(byte_counts_s), .busy(busy_s),
    .bad_port(bad_port_s)
`ifdef EP2_DEMUX_DROP_COUNT_EN
    , .drop_count(drop_count_s), .frame_count(frame_count_s)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture every FIFO strobe and bad_port pulse away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (fifo_write != 4'b0) begin
        wr_strb.push_back(fifo_write);
        wr_data.push_back(fifo_data);
      end
      if (bad_port) bp_cnt++;
    end
  end

  task automatic put(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("put_ready", 64'(n < 100), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_wr(input string tag, input logic [3:0] strb, input logic [7:0] d);
    check({tag, "_avail"}, 64'(wr_strb.size() > 0), 64'd1);
    if (wr_strb.size() > 0) begin
      check({tag, "_strb"}, 64'(wr_strb.pop_front()), 64'(strb));
      check({tag, "_data"}, 64'(wr_data.pop_front()), 64'(d));
    end
  endtask

  task automatic check_counts(input string tag);
    for (int p = 0; p < 4; p++) begin
      check($sformatf("%s_cnt%0d", tag, p), 64'(byte_counts[p*32 +: 32]), 64'(exp_cnt[p]));
      check($sformatf("%s_scnt%0d", tag, p), 64'(byte_counts_s[p*3 +: 3]), 64'(exp_cnt[p] % 8));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; fifo_full = 4'b0;
    for (int p = 0; p < 4; p++) exp_cnt[p] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_bad_port", 64'(bad_port), 64'd0);
    check("rst_fifo_write", 64'(fifo_write), 64'd0);
    check_counts("rst");
    @(posedge clk); #1;

    // Test 1: port 2, four bytes back to back
    put(8'h02); put(8'h00); put(8'h04);
    put(8'h11); put(8'h22); put(8'h33);
    check("t1_busy_mid", 64'(busy), 64'd1);
    put(8'h44);
    check("t1_busy_end", 64'(busy), 64'd0);
    expect_wr("t1_b0", 4'b0100, 8'h11);
    expect_wr("t1_b1", 4'b0100, 8'h22);
    expect_wr("t1_b2", 4'b0100, 8'h33);
    expect_wr("t1_b3", 4'b0100, 8'h44);
    exp_cnt[2] = 4;
    check_counts("t1");

    // Test 2: port 1 stalls for five cycles on fifo_full
    put(8'h01); put(8'h00); put(8'h03); put(8'hAA);
    fifo_full = 4'b0010; in_data = 8'hBB; in_valid = 1'b1;
    stall = 0;
    repeat (5) begin
      @(negedge clk);
      if (!in_ready) stall++;
      @(posedge clk); #1;
    end
    fifo_full = 4'b0; in_valid = 1'b0;
    check("t2_stall_cycles", 64'(stall), 64'd5);
    check("t2_no_wr_in_stall", 64'(wr_strb.size()), 64'd1);
    put(8'hBB); put(8'hCC);
    expect_wr("t2_b0", 4'b0010, 8'hAA);
    expect_wr("t2_b1", 4'b0010, 8'hBB);
    expect_wr("t2_b2", 4'b0010, 8'hCC);
    check("t2_wr_total", 64'(wr_strb.size()), 64'd0);
    exp_cnt[1] = 3;
    check_counts("t2");

    // Test 3: bad port 5 discarded, then port 0 one byte
    put(8'h05); put(8'h00); put(8'h02);
    check("t3_bad_port_now", 64'(bad_port), 64'd1);
    put(8'h9A); put(8'h9B);
    check("t3_no_write_discard", 64'(wr_strb.size()), 64'd0);
    check("t3_busy_after_discard", 64'(busy), 64'd0);
    put(8'h00); put(8'h00); put(8'h01); put(8'h7E);
    check("t3_bad_port_pulses", 64'(bp_cnt), 64'd1);
    expect_wr("t3_b0", 4'b0001, 8'h7E);
    exp_cnt[0] = 1;
    check_counts("t3");
`ifdef EP2_DEMUX_DROP_COUNT_EN
    check("t3_drop_count", 64'(drop_count), 64'd2);
    check("t3_frame_count", 64'(frame_count), 64'd4);
`endif

    // Test 4: zero-length frame then one byte, both port 3
    put(8'h03); put(8'h00); put(8'h00);
    check("t4_idle_after_len0", 64'(busy), 64'd0);
    check("t4_no_write_len0", 64'(wr_strb.size()), 64'd0);
    put(8'h03); put(8'h00); put(8'h01); put(8'h55);
    expect_wr("t4_b0", 4'b1000, 8'h55);
    exp_cnt[3] = 1;
    check_counts("t4");

    // Test 5: wrap of the 3-bit counters in the second instance
    put(8'h00); put(8'h00); put(8'h06);
    for (int i = 0; i < 6; i++) put(8'(8'h60 + i));
    exp_cnt[0] = 7;
    check_counts("t5_pre");
    put(8'h00); put(8'h00); put(8'h01); put(8'hEE);
    exp_cnt[0] = 8;
    check_counts("t5_wrap");
    check("t5_small_wrapped", 64'(byte_counts_s[2:0]), 64'd0);
    wr_strb.delete(); wr_data.delete();

    // Test 6: reset mid-payload, then clean frame with upper port bits set
    put(8'h01); put(8'h00); put(8'h0A);
    for (int i = 0; i < 4; i++) put(8'(8'hC0 + i));
    check("t6_busy_before_rst", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_fifo_write", 64'(fifo_write), 64'd0);
    for (int p = 0; p < 4; p++) exp_cnt[p] = 0;
    check_counts("t6_rst");
`ifdef EP2_DEMUX_DROP_COUNT_EN
    check("t6_drop_rst", 64'(drop_count), 64'd0);
    check("t6_frame_rst", 64'(frame_count), 64'd0);
`endif
    @(posedge clk); #1;
    wr_strb.delete(); wr_data.delete();
    put(8'h08); put(8'h00); put(8'h02); put(8'hA1); put(8'hA2);
    expect_wr("t6_b0", 4'b0001, 8'hA1);
    expect_wr("t6_b1", 4'b0001, 8'hA2);
    check("t6_wr_total", 64'(wr_strb.size()), 64'd0);
    exp_cnt[0] = 2;
    check_counts("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
